// File: rtl/pulse_rate_pkg.sv
// Shared encodings for the pulse rate governor.
// Class codes double as the rate command encoding.
package pulse_rate_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'b00,
        CLS_FAST   = 2'b01,
        CLS_NORMAL = 2'b10,
        CLS_SLOW   = 2'b11
    } cls_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PEND = 2'b10
    } state_e;

    localparam int MATCH_W = 3;

endpackage

// File: rtl/pulse_rate_governor_gap_classifier.sv
// Measures low-gaps between pulses on x and classifies them.
// Also raises stall once a gap reaches the timeout.
module gap_classifier
    import pulse_rate_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int FAST_MAX   = 1,
    parameter int NORMAL_MAX = 2,
    parameter int TIMEOUT    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x_i,
    output cls_e       cls_o,
    output logic       cls_valid_o,
    output logic       stall_o
);

    localparam logic [CNT_W-1:0] GAP_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] F_MAX   = CNT_W'(FAST_MAX);
    localparam logic [CNT_W-1:0] N_MAX   = CNT_W'(NORMAL_MAX);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

    logic             armed_q, armed_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] gap_inc;
    cls_e             cls_q, cls_d;
    cls_e             gap_cls;
    logic             cls_valid_q, cls_valid_d;
    logic             stall_q, stall_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q     <= 1'b0;
            gap_q       <= '0;
            cls_q       <= CLS_NONE;
            cls_valid_q <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            armed_q     <= armed_d;
            gap_q       <= gap_d;
            cls_q       <= cls_d;
            cls_valid_q <= cls_valid_d;
            stall_q     <= stall_d;
        end
    end

    always_comb begin
        gap_cls = CLS_SLOW;
        unique case (1'b1)
            (gap_q <= F_MAX):                     gap_cls = CLS_FAST;
            (gap_q > F_MAX && gap_q <= N_MAX):    gap_cls = CLS_NORMAL;
            (gap_q > N_MAX):                      gap_cls = CLS_SLOW;
            default:                              gap_cls = CLS_SLOW;
        endcase
    end

    // Saturate rather than wrap so very long gaps still read as SLOW.
    assign gap_inc = (gap_q == GAP_MAX) ? gap_q : gap_q + CNT_W'(1);

    always_comb begin
        armed_d     = armed_q;
        gap_d       = gap_q;
        cls_d       = cls_q;
        cls_valid_d = 1'b0;
        stall_d     = stall_q;
        if (!armed_q) begin
            if (x_i) armed_d = 1'b1;
        end else if (x_i) begin
            gap_d   = '0;
            stall_d = 1'b0;
            if (gap_q != '0) begin
                cls_d       = gap_cls;
                cls_valid_d = 1'b1;
            end
        end else begin
            gap_d = gap_inc;
            if (gap_inc >= TMO) stall_d = 1'b1;
        end
    end

    assign cls_o       = cls_q;
    assign cls_valid_o = cls_valid_q;
    assign stall_o     = stall_q;

endmodule

// File: rtl/pulse_rate_governor.sv
// Rate governor: debounces gap classes into a stable command.
// A stall overrides everything and forces the SLOW command.
module pulse_rate_governor
    import pulse_rate_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int FAST_MAX   = 1,
    parameter int NORMAL_MAX = 2,
    parameter int CONFIRM    = 2,
    parameter int TIMEOUT    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    output logic [1:0] cls,
    output logic       cls_valid,
    output logic [1:0] cmd,
    output logic       cmd_chg,
    output logic       stall
);

    localparam logic [MATCH_W-1:0] CONF = MATCH_W'(CONFIRM);

    cls_e               cls_w;
    logic               cls_valid_w;
    logic               stall_w;
    logic               stall_rise;

    state_e             state_q, state_d;
    cls_e               cmd_q, cmd_d;
    cls_e               cand_q, cand_d;
    logic [MATCH_W-1:0] cnt_q, cnt_d;
    logic               chg_q, chg_d;
    logic               stall_prev_q;

    gap_classifier #(
        .CNT_W      (CNT_W),
        .FAST_MAX   (FAST_MAX),
        .NORMAL_MAX (NORMAL_MAX),
        .TIMEOUT    (TIMEOUT)
    ) u_gap (
        .clk         (clk),
        .rst         (rst),
        .x_i         (x),
        .cls_o       (cls_w),
        .cls_valid_o (cls_valid_w),
        .stall_o     (stall_w)
    );

    assign stall_rise = stall_w & ~stall_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= CLS_NONE;
            cand_q       <= CLS_NONE;
            cnt_q        <= '0;
            chg_q        <= 1'b0;
            stall_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            chg_q        <= chg_d;
            stall_prev_q <= stall_w;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        chg_d   = 1'b0;
        if (stall_rise) begin
            cmd_d   = CLS_SLOW;
            chg_d   = (cmd_q != CLS_SLOW);
            cand_d  = CLS_NONE;
            cnt_d   = '0;
            state_d = ST_RUN;
        end else if (cls_valid_w) begin
            unique case (state_q)
                ST_IDLE: begin
                    cmd_d   = cls_w;
                    chg_d   = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (cls_w != cmd_q) begin
                        if (CONFIRM == 1) begin
                            cmd_d = cls_w;
                            chg_d = 1'b1;
                        end else begin
                            cand_d  = cls_w;
                            cnt_d   = MATCH_W'(1);
                            state_d = ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (cls_w == cand_q) begin
                        if (cnt_q + MATCH_W'(1) >= CONF) begin
                            cmd_d   = cand_q;
                            chg_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_RUN;
                        end else begin
                            cnt_d = cnt_q + MATCH_W'(1);
                        end
                    end else if (cls_w == cmd_q) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cand_d = cls_w;
                        cnt_d  = MATCH_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign cls       = cls_w;
    assign cls_valid = cls_valid_w;
    assign cmd       = cmd_q;
    assign cmd_chg   = chg_q;
    assign stall     = stall_w;

endmodule

// File: tb/tb_pulse_rate_governor.sv
// Directed bench for pulse_rate_governor with default parameters.
module tb_pulse_rate_governor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x   = 1'b0;
    logic [1:0] cls;
    logic       cls_valid;
    logic [1:0] cmd;
    logic       cmd_chg;
    logic       stall;

    int n_chk = 0;
    int n_err = 0;

    pulse_rate_governor dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .cls       (cls),
        .cls_valid (cls_valid),
        .cmd       (cmd),
        .cmd_chg   (cmd_chg),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v);
        x = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag,
                           input logic [1:0] e_cls, input logic e_cv,
                           input logic [1:0] e_cmd, input logic e_chg,
                           input logic e_st);
        check({tag, ".cls"},   8'(cls),       8'(e_cls));
        check({tag, ".cv"},    8'(cls_valid), 8'(e_cv));
        check({tag, ".cmd"},   8'(cmd),       8'(e_cmd));
        check({tag, ".chg"},   8'(cmd_chg),   8'(e_chg));
        check({tag, ".stall"}, 8'(stall),     8'(e_st));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all("rst", 2'b00, 0, 2'b00, 0, 0);
        rst = 1'b1;

        // first fast pulse, IDLE -> RUN
        step(1); chk_all("arm", 2'b00, 0, 2'b00, 0, 0);
        step(0);
        step(1); chk_all("c1", 2'b01, 1, 2'b00, 0, 0);
        step(0); chk_all("m1", 2'b01, 0, 2'b01, 1, 0);

        // two NORMAL gaps needed to switch
        step(0);
        step(1); chk_all("n1", 2'b10, 1, 2'b01, 0, 0);
        step(0); chk_all("n1d", 2'b10, 0, 2'b01, 0, 0);
        step(0);
        step(1); chk_all("n2", 2'b10, 1, 2'b01, 0, 0);
        step(0); chk_all("n2d", 2'b10, 0, 2'b10, 1, 0);

        // stall after 12 zeros (one already counted)
        repeat (10) step(0);
        chk_all("pre_st", 2'b10, 0, 2'b10, 0, 0);
        step(0); chk_all("st", 2'b10, 0, 2'b10, 0, 1);
        step(0); chk_all("st_cmd", 2'b10, 0, 2'b11, 1, 1);
        step(0); chk_all("st_hold", 2'b10, 0, 2'b11, 0, 1);
        check("gap14", 8'(dut.u_gap.gap_q), 8'd14);
        step(1); chk_all("st_end", 2'b11, 1, 2'b11, 0, 0);
        step(1); chk_all("hold1", 2'b11, 0, 2'b11, 0, 0);

        // return to FAST command
        step(0);
        step(1); chk_all("f1", 2'b01, 1, 2'b11, 0, 0);
        step(0); chk_all("f1d", 2'b01, 0, 2'b11, 0, 0);
        step(1); chk_all("f2", 2'b01, 1, 2'b11, 0, 0);
        step(0); chk_all("f2d", 2'b01, 0, 2'b01, 1, 0);

        // gap 3 then gap 1 aborts PEND
        step(0); step(0);
        step(1); chk_all("a1", 2'b11, 1, 2'b01, 0, 0);
        step(0); chk_all("a1d", 2'b11, 0, 2'b01, 0, 0);
        step(1); chk_all("a2", 2'b01, 1, 2'b01, 0, 0);
        step(0); chk_all("a2d", 2'b01, 0, 2'b01, 0, 0);
        step(0); step(0);
        step(1); chk_all("a3", 2'b11, 1, 2'b01, 0, 0);
        step(0); chk_all("a3d", 2'b11, 0, 2'b01, 0, 0);

        // asynchronous reset while in PEND
        #2 rst = 1'b0;
        #1 chk_all("arst", 2'b00, 0, 2'b00, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(0);
        step(1); chk_all("rearm", 2'b00, 0, 2'b00, 0, 0);
        step(0); chk_all("rearm_d", 2'b00, 0, 2'b00, 0, 0);
        step(1); chk_all("r1", 2'b01, 1, 2'b00, 0, 0);
        step(0); chk_all("r1d", 2'b01, 0, 2'b01, 1, 0);

        // held high, then saturating gap from IDLE
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        step(1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("held_cv", 8'(cls_valid), 8'd0);
        end
        for (int i = 1; i <= 20; i++) begin
            step(0);
            if (i == 11) chk_all("s11", 2'b00, 0, 2'b00, 0, 0);
            if (i == 12) chk_all("s12", 2'b00, 0, 2'b00, 0, 1);
            if (i == 13) chk_all("s13", 2'b00, 0, 2'b11, 1, 1);
            if (i == 14) chk_all("s14", 2'b00, 0, 2'b11, 0, 1);
            if (i >= 15) check("sat", 8'(dut.u_gap.gap_q), 8'd15);
        end
        step(1); chk_all("sat_end", 2'b11, 1, 2'b11, 0, 0);
        step(0); chk_all("sat_d", 2'b11, 0, 2'b11, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
